tx_packet_ctrl: RTL and testbench

TX_PACKET_CTRL -- requirements
Module: tx_packet_ctrl

---
 rtl/tx_packet_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_tx_packet_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_ctrl.sv
// tx_packet_ctrl: payload byte FIFO plus framer that serialises preamble and payload as MSB-first dibits.
// Define TX_PKT_CRC8_EN to append a CRC-8 byte (poly 0x07, init 0x00) after the payload.
module tx_packet_ctrl #(
    parameter int         DEPTH    = 64,
    parameter logic [7:0] PREAMBLE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     len_wr_en,
    input  logic [7:0]               len_data_in,
    output logic [7:0]               len_data_out,
    input  logic                     pkt_wr_en,
    input  logic [7:0]               pkt_data_in,
    input  logic                     status_wr_en,
    input  logic [7:0]               status_data_in,
    input  logic                     status_rd_en,
    output logic [7:0]               status_data_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [1:0]               to_lvds
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [8:0]    DEPTH9   = 9'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_PAY, S_CRC, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    dib_q, dib_d;
    logic [1:0]    dib_nx;
    logic [8:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    lvds_q, lvds_d;
    logic [7:0]    len_q, len_d;
    logic          done_q, over_q, under_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q, count_d;
    logic [7:0]    rd_data;
    logic          full, empty, push, pop, busy, start_req;
    logic          set_done, set_under, set_over, crc_clr, load_byte;
    logic          unused_status;

    function automatic logic [1:0] dibit(input logic [7:0] b, input logic [1:0] idx);
        case (idx)
            2'd0:    return b[7:6];
            2'd1:    return b[5:4];
            2'd2:    return b[3:2];
            default: return b[1:0];
        endcase
    endfunction

`ifdef TX_PKT_CRC8_EN
    logic [7:0] crc_q, crc_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (crc_clr) begin
            crc_d = 8'h00;
        end else if (pop) begin
            crc_d = crc8_step(crc_q, rd_data);
        end
    end

    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end
`endif

    assign unused_status   = ^status_data_in[7:1];
    assign start_req       = status_wr_en & status_data_in[0];
    assign busy            = (state_q != S_IDLE);
    assign full            = (count_q == FULL_LVL);
    assign empty           = (count_q == '0);
    assign rd_data         = mem_q[rd_ptr_q];
    assign dib_nx          = dib_q + 2'd1;
    // A pop frees a slot in the same cycle, so a push at full still lands.
    assign push            = pkt_wr_en & (~full | pop);
    assign set_over        = pkt_wr_en & full & ~pop;
    assign len_data_out    = len_q;
    assign status_data_out = {4'b0000, under_q, over_q, done_q, busy};
    assign fifo_level      = count_q;
    assign to_lvds         = lvds_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        len_d = len_q;
        if (len_wr_en && !busy) begin
            len_d = ({1'b0, len_data_in} > DEPTH9) ? DEPTH9[7:0] : len_data_in;
        end
    end

    // The state register describes the dibit currently driven on to_lvds.
    always_comb begin
        state_d    = state_q;
        dib_d      = dib_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        lvds_d     = 2'b00;
        pop        = 1'b0;
        set_done   = 1'b0;
        set_under  = 1'b0;
        crc_clr    = 1'b0;
        load_byte  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req && len_q != 8'd0) begin
                    state_d    = S_PRE;
                    dib_d      = 2'd0;
                    shift_d    = PREAMBLE;
                    lvds_d     = dibit(PREAMBLE, 2'd0);
                    byte_cnt_d = 9'd0;
                    crc_clr    = 1'b1;
                end
            end
            S_PRE: begin
                if (dib_q != 2'd3) begin
                    dib_d  = dib_nx;
                    lvds_d = dibit(shift_q, dib_nx);
                end else begin
                    load_byte = 1'b1;
                end
            end
            S_PAY: begin
                if (dib_q != 2'd3) begin
                    dib_d  = dib_nx;
                    lvds_d = dibit(shift_q, dib_nx);
                end else if (byte_cnt_q == {1'b0, len_q}) begin
`ifdef TX_PKT_CRC8_EN
                    state_d = S_CRC;
                    dib_d   = 2'd0;
                    shift_d = crc_q;
                    lvds_d  = dibit(crc_q, 2'd0);
`else
                    state_d = S_DONE;
`endif
                end else begin
                    load_byte = 1'b1;
                end
            end
            S_CRC: begin
                if (dib_q != 2'd3) begin
                    dib_d  = dib_nx;
                    lvds_d = dibit(shift_q, dib_nx);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                set_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Next payload byte is due: pop it onto the line or abort on an empty FIFO.
        if (load_byte) begin
            if (empty) begin
                set_under = 1'b1;
                state_d   = S_IDLE;
            end else begin
                pop        = 1'b1;
                state_d    = S_PAY;
                dib_d      = 2'd0;
                shift_d    = rd_data;
                lvds_d     = dibit(rd_data, 2'd0);
                byte_cnt_d = byte_cnt_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pkt_data_in;
        end
        shift_q <= shift_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dib_q      <= 2'd0;
            byte_cnt_q <= 9'd0;
            lvds_q     <= 2'b00;
            len_q      <= 8'd0;
            done_q     <= 1'b0;
            over_q     <= 1'b0;
            under_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            dib_q      <= dib_d;
            byte_cnt_q <= byte_cnt_d;
            lvds_q     <= lvds_d;
            len_q      <= len_d;
            // Sticky flags: a set in the read cycle beats the clear.
            done_q     <= set_done  | (done_q  & ~status_rd_en);
            over_q     <= set_over  | (over_q  & ~status_rd_en);
            under_q    <= set_under | (under_q & ~status_rd_en);
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tx_packet_ctrl.sv
// Scenario bench for tx_packet_ctrl: expected dibit streams are queued when a packet is set up and
// popped as the line is sampled on each falling edge.
module tb_tx_packet_ctrl;

    localparam int         DEPTH = 64;
    localparam logic [7:0] PRE   = 8'hA5;

    logic                   clk;
    logic                   reset_n;
    logic                   len_wr_en;
    logic [7:0]             len_data_in;
    logic [7:0]             len_data_out;
    logic                   pkt_wr_en;
    logic [7:0]             pkt_data_in;
    logic                   status_wr_en;
    logic [7:0]             status_data_in;
    logic                   status_rd_en;
    logic [7:0]             status_data_out;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [1:0]             to_lvds;

    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_q[$];
    logic [1:0] e;

    tx_packet_ctrl #(.DEPTH(DEPTH), .PREAMBLE(PRE)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .len_wr_en       (len_wr_en),
        .len_data_in     (len_data_in),
        .len_data_out    (len_data_out),
        .pkt_wr_en       (pkt_wr_en),
        .pkt_data_in     (pkt_data_in),
        .status_wr_en    (status_wr_en),
        .status_data_in  (status_data_in),
        .status_rd_en    (status_rd_en),
        .status_data_out (status_data_out),
        .fifo_level      (fifo_level),
        .to_lvds         (to_lvds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clear_strobes;
        len_wr_en    = 1'b0;
        pkt_wr_en    = 1'b0;
        status_wr_en = 1'b0;
        status_rd_en = 1'b0;
    endtask

    task automatic apply_reset;
        reset_n        = 1'b0;
        clear_strobes;
        len_data_in    = 8'h00;
        pkt_data_in    = 8'h00;
        status_data_in = 8'h00;
        tick;
        tick;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic push_byte(input logic [7:0] b);
        pkt_wr_en   = 1'b1;
        pkt_data_in = b;
        tick;
        pkt_wr_en   = 1'b0;
    endtask

    task automatic write_len(input logic [7:0] l);
        len_wr_en   = 1'b1;
        len_data_in = l;
        tick;
        len_wr_en   = 1'b0;
    endtask

    task automatic status_read;
        status_rd_en = 1'b1;
        tick;
        status_rd_en = 1'b0;
    endtask

    task automatic start_pkt;
        status_wr_en   = 1'b1;
        status_data_in = 8'h01;
    endtask

    task automatic sb_push_byte(input logic [7:0] b);
        for (int i = 7; i > 0; i -= 2) begin
            exp_q.push_back({b[i], b[i-1]});
        end
    endtask

    // Bit-serial CRC-8, poly 0x07, processing one data bit at a time.
    function automatic logic [7:0] crc_upd(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic test_reset;
        total++; if (to_lvds !== 2'b00) begin bad++; $display("FAIL reset_lvds got=%b exp=00", to_lvds); end
        total++; if (fifo_level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        total++; if (status_data_out !== 8'h00) begin bad++; $display("FAIL reset_status got=%h exp=00", status_data_out); end
        total++; if (len_data_out !== 8'h00) begin bad++; $display("FAIL reset_len got=%h exp=00", len_data_out); end
    endtask

    task automatic test_single;
        push_byte(8'h01);
        write_len(8'd1);
        total++; if (len_data_out !== 8'd1) begin bad++; $display("FAIL single_len got=%0d exp=1", len_data_out); end
        total++; if (fifo_level !== 7'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
        sb_push_byte(PRE);
        sb_push_byte(8'h01);
`ifdef TX_PKT_CRC8_EN
        sb_push_byte(crc_upd(8'h00, 8'h01));
`endif
        exp_q.push_back(2'b00);
        start_pkt;
        while (exp_q.size() != 0) begin
            tick;
            clear_strobes;
            e = exp_q.pop_front();
            total++; if (to_lvds !== e) begin bad++; $display("FAIL single_dibit got=%b exp=%b", to_lvds, e); end
        end
        total++; if (status_data_out !== 8'h01) begin bad++; $display("FAIL single_done_busy got=%h exp=01", status_data_out); end
        tick;
        total++; if (status_data_out !== 8'h02) begin bad++; $display("FAIL single_status got=%h exp=02", status_data_out); end
        status_read;
        total++; if (status_data_out !== 8'h00) begin bad++; $display("FAIL single_clear got=%h exp=00", status_data_out); end
        total++; if (fifo_level !== '0) begin bad++; $display("FAIL single_drained got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_len_sat;
        write_len(8'd200);
        total++; if (len_data_out !== 8'(DEPTH)) begin bad++; $display("FAIL len_sat200 got=%0d exp=%0d", len_data_out, DEPTH); end
        write_len(8'(DEPTH + 1));
        total++; if (len_data_out !== 8'(DEPTH)) begin bad++; $display("FAIL len_sat65 got=%0d exp=%0d", len_data_out, DEPTH); end
        write_len(8'd0);
        total++; if (len_data_out !== 8'd0) begin bad++; $display("FAIL len_zero got=%0d exp=0", len_data_out); end
        start_pkt;
        tick;
        clear_strobes;
        total++; if (status_data_out !== 8'h00) begin bad++; $display("FAIL len0_start got=%h exp=00", status_data_out); end
        tick;
        total++; if (to_lvds !== 2'b00) begin bad++; $display("FAIL len0_lvds got=%b exp=00", to_lvds); end
    endtask

    task automatic test_underrun;
        push_byte(8'h3C);
        push_byte(8'hC3);
        write_len(8'd4);
        sb_push_byte(PRE);
        sb_push_byte(8'h3C);
        sb_push_byte(8'hC3);
        exp_q.push_back(2'b00);
        start_pkt;
        while (exp_q.size() != 0) begin
            tick;
            clear_strobes;
            e = exp_q.pop_front();
            total++; if (to_lvds !== e) begin bad++; $display("FAIL under_dibit got=%b exp=%b", to_lvds, e); end
        end
        total++; if (status_data_out !== 8'h08) begin bad++; $display("FAIL under_status got=%h exp=08", status_data_out); end
        tick;
        total++; if (to_lvds !== 2'b00) begin bad++; $display("FAIL under_idle got=%b exp=00", to_lvds); end
        status_read;
        total++; if (status_data_out !== 8'h00) begin bad++; $display("FAIL under_clear got=%h exp=00", status_data_out); end
    endtask

    task automatic test_second_start;
        int i;
        push_byte(8'h5A);
        push_byte(8'h96);
        write_len(8'd2);
        sb_push_byte(PRE);
        sb_push_byte(8'h5A);
        sb_push_byte(8'h96);
`ifdef TX_PKT_CRC8_EN
        sb_push_byte(crc_upd(crc_upd(8'h00, 8'h5A), 8'h96));
`endif
        for (int k = 0; k < 7; k++) exp_q.push_back(2'b00);
        start_pkt;
        i = 0;
        while (exp_q.size() != 0) begin
            tick;
            clear_strobes;
            e = exp_q.pop_front();
            total++; if (to_lvds !== e) begin bad++; $display("FAIL second_dibit idx=%0d got=%b exp=%b", i, to_lvds, e); end
            if (i == 6) begin
                start_pkt;
                len_wr_en   = 1'b1;
                len_data_in = 8'd5;
            end
            i++;
        end
        total++; if (len_data_out !== 8'd2) begin bad++; $display("FAIL second_len got=%0d exp=2", len_data_out); end
        total++; if (status_data_out !== 8'h02) begin bad++; $display("FAIL second_status got=%h exp=02", status_data_out); end
        total++; if (fifo_level !== '0) begin bad++; $display("FAIL second_level got=%0d exp=0", fifo_level); end
        status_read;
    endtask

    task automatic test_overflow;
        for (int k = 0; k <= DEPTH; k++) push_byte(8'(k));
        total++; if (fifo_level !== 7'(DEPTH)) begin bad++; $display("FAIL ovf_level got=%0d exp=%0d", fifo_level, DEPTH); end
        total++; if (status_data_out[2] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", status_data_out[2]); end
        status_read;
        total++; if (status_data_out[2] !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", status_data_out[2]); end
        write_len(8'd1);
        start_pkt;
        for (int k = 0; k < 4; k++) begin
            tick;
            clear_strobes;
        end
        pkt_wr_en   = 1'b1;
        pkt_data_in = 8'hEE;
        tick;
        clear_strobes;
        total++; if (fifo_level !== 7'(DEPTH)) begin bad++; $display("FAIL pushpop_level got=%0d exp=%0d", fifo_level, DEPTH); end
        total++; if (status_data_out[2] !== 1'b0) begin bad++; $display("FAIL pushpop_ovf got=%b exp=0", status_data_out[2]); end
        for (int k = 0; k < 8; k++) tick;
    endtask

    task automatic test_reset_mid;
        apply_reset;
        push_byte(8'hFF);
        push_byte(8'hFF);
        push_byte(8'hFF);
        write_len(8'd3);
        start_pkt;
        for (int k = 0; k < 7; k++) begin
            tick;
            clear_strobes;
        end
        total++; if (to_lvds !== 2'b11) begin bad++; $display("FAIL mid_before got=%b exp=11", to_lvds); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (to_lvds !== 2'b00) begin bad++; $display("FAIL mid_async_lvds got=%b exp=00", to_lvds); end
        @(negedge clk);
        reset_n = 1'b1;
        total++; if (fifo_level !== '0) begin bad++; $display("FAIL mid_level got=%0d exp=0", fifo_level); end
        total++; if (status_data_out !== 8'h00) begin bad++; $display("FAIL mid_status got=%h exp=00", status_data_out); end
        total++; if (len_data_out !== 8'h00) begin bad++; $display("FAIL mid_len got=%h exp=00", len_data_out); end
        tick;
        tick;
        total++; if (to_lvds !== 2'b00) begin bad++; $display("FAIL mid_after got=%b exp=00", to_lvds); end
    endtask

    initial begin
        reset_n = 1'b0;
        apply_reset;
        test_reset;
        test_single;
        test_len_sat;
        test_underrun;
        test_second_start;
        test_overflow;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
